// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the request collector and arbiter
//
// Purpose: request/grant vector type, one-hot grant constants and the
//          per-client slot state enum used by req_collector and req_slot.
// Ports:   none (package).
package arb_pkg;

  localparam int NUM_REQ = 3;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  localparam req_vec_t G1     = 3'b001;
  localparam req_vec_t G2     = 3'b010;
  localparam req_vec_t G3     = 3'b100;
  localparam req_vec_t G_NONE = 3'b000;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FULL    = 2'd2
  } slot_state_e;

endpackage

// File: rtl/req_slot.sv
// rtl/req_slot.sv - one client's saturating pending counter
//
// Purpose: counts accepted-but-not-granted transactions for a single client,
//          drives its ready, its request term to the arbiter and flags a
//          grant that arrives while nothing is pending.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   valid_i      client offers one request this cycle
//   grant_i      arbiter grant bit for this client
//   ready_o      slot can accept (count below DEPTH)
//   req_o        request term to the arbiter
//   spurious_o   grant seen while count is 0 (combinational)
//   count_o      registered pending count
module req_slot
  import arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             grant_i,
  output logic             ready_o,
  output logic             req_o,
  output logic             spurious_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  slot_state_e      state;
  logic             acc, ret;

  always_comb begin
    state = SLOT_PENDING;
    if (count_q == '0) begin
      state = SLOT_EMPTY;
    end else if (count_q == FULL_CNT) begin
      state = SLOT_FULL;
    end

    // Ready comes from the registered count only, so a grant in the same
    // cycle never opens a FULL slot early.
    ready_o    = (state != SLOT_FULL);
    acc        = valid_i & ready_o;
    ret        = grant_i & (state != SLOT_EMPTY);
    spurious_o = grant_i & (state == SLOT_EMPTY);

    // Saturating (count - grant): drop req while the last pending entry is
    // being granted so the arbiter cannot grant it twice.
    req_o = grant_i ? (count_q > ONE_CNT) : (state != SLOT_EMPTY);

    count_d = count_q;
    if (acc && !ret) begin
      count_d = count_q + ONE_CNT;
    end else if (ret && !acc) begin
      count_d = count_q - ONE_CNT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/req_collector.sv
// rtl/req_collector.sv - collects client request pulses into arbiter req levels
//
// Purpose: three per-client pending counters feeding a level-sensitive
//          arbiter request vector; each one-hot grant retires one pending
//          transaction. Sticky error flags catch spurious and multi-bit grants.
// Ports:
//   clk             system clock
//   reset           asynchronous active-high reset
//   client_valid    per-client request offer
//   client_ready    per-client accept capability
//   granted_req     one-hot (or zero) grant from the arbiter
//   req             request vector to the arbiter
//   pending_cnt     packed registered counts, client 0 in the LSBs
//   err_clr         synchronous clear of the sticky flags
//   spurious_grant  sticky: grant for a client with nothing pending
//   multi_grant     sticky: more than one grant bit set
module req_collector
  import arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               client_valid,
  output logic [2:0]               client_ready,
  input  logic [2:0]               granted_req,
  output logic [2:0]               req,
  output logic [NUM_REQ*CNT_W-1:0] pending_cnt,
  input  logic                     err_clr,
  output logic                     spurious_grant,
  output logic                     multi_grant
);

  req_vec_t spur_vec;
  logic     spur_any, multi_now;
  logic     spurious_q, spurious_d;
  logic     multi_q, multi_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    req_slot #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (client_valid[i]),
      .grant_i    (granted_req[i]),
      .ready_o    (client_ready[i]),
      .req_o      (req[i]),
      .spurious_o (spur_vec[i]),
      .count_o    (pending_cnt[i*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    spur_any = |spur_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_now = ((granted_req & (granted_req - 3'b001)) != G_NONE);

    // A new error in the clear cycle wins over err_clr.
    spurious_d = spur_any  | (spurious_q & ~err_clr);
    multi_d    = multi_now | (multi_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spurious_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      spurious_q <= spurious_d;
      multi_q    <= multi_d;
    end
  end

  assign spurious_grant = spurious_q;
  assign multi_grant    = multi_q;

endmodule
